// File: rtl/nonce_pkg.sv
// Shared types for the multi-core nonce collector.
// Default widths, frame layout and serializer states.
package nonce_pkg;

  localparam int NONCE_W_DEF   = 32;
  localparam int NUM_CORES_DEF = 4;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ID_W_DEF = id_w(NUM_CORES_DEF);

  typedef struct packed {
    logic [ID_W_DEF-1:0]    id;
    logic [NONCE_W_DEF-1:0] nonce;
  } nonce_frame_t;

  typedef enum logic {
    IDLE,
    SHIFT
  } ser_state_t;

endpackage

// File: rtl/nonce_fifo.sv
// Synchronous FIFO of nonce frames.
// Full/empty come from an extra pointer wrap bit.
module nonce_fifo
  import nonce_pkg::*;
#(
  parameter type T     = nonce_frame_t,
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  T            wdata,
  input  logic        pop,
  output T            rdata,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  T           mem [DEPTH];
  logic [AW:0] wp;
  logic [AW:0] rp;
  logic        do_push;
  logic        do_pop;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign count = wp - rp;
  assign rdata = mem[rp[AW-1:0]];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/nonce_collector.sv
// Collects hits from several hash cores, queues them with a core
// tag and streams each frame out serially, LSB first.
module nonce_collector
  import nonce_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEF,
  parameter int NONCE_W   = NONCE_W_DEF,
  parameter int DEPTH     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CORES-1:0]         valid,
  input  logic [NUM_CORES-1:0]         success,
  input  logic [NUM_CORES*NONCE_W-1:0] nonce_i,
  input  logic                         readready,
  output logic                         nonce_o,
  output logic                         nonce_valid_o,
  output logic                         frame_last_o,
  output logic                         overflow,
  output logic [7:0]                   drop_count,
  output logic [$clog2(DEPTH):0]       fill_level
);

  localparam int ID_W    = id_w(NUM_CORES);
  localparam int FRAME_W = NONCE_W + ID_W;
  localparam int CNT_W   = $clog2(FRAME_W);

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [NONCE_W-1:0] nonce;
  } frame_t;

  logic [NUM_CORES-1:0] hit;
  logic [NUM_CORES-1:0] hold_v;
  logic [NUM_CORES-1:0] gmask;
  logic [NONCE_W-1:0]   hold_n [NUM_CORES];
  logic [ID_W-1:0]      ptr;
  logic [ID_W-1:0]      gidx;
  logic                 gfound;
  logic                 grant;
  logic                 drop;
  logic                 pop;
  logic                 full;
  logic                 empty;
  frame_t               wdata;
  frame_t               rdata;

  ser_state_t           state_q, state_d;
  logic [FRAME_W-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 bit_d, vld_d, last_d;

  assign hit = valid & success;

  // Round-robin search starting at ptr; first occupied reg wins.
  always_comb begin
    int j;
    j      = 0;
    gidx   = '0;
    gfound = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_CORES) j = j - NUM_CORES;
      if (!gfound && hold_v[j]) begin
        gfound = 1'b1;
        gidx   = ID_W'(j);
      end
    end
  end

  assign grant = gfound && (!full || pop);
  assign gmask = grant ? (NUM_CORES'(1) << gidx) : '0;
  assign drop  = |(hit & hold_v & ~gmask);

  assign wdata.id    = gidx;
  assign wdata.nonce = hold_n[gidx];

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v     <= '0;
      ptr        <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      for (int k = 0; k < NUM_CORES; k++) begin
        if (hit[k] && (!hold_v[k] || gmask[k]))
          hold_v[k] <= 1'b1;
        else if (gmask[k])
          hold_v[k] <= 1'b0;
      end
      if (grant)
        ptr <= (gidx == ID_W'(NUM_CORES - 1))
             ? '0 : gidx + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF)
          drop_count <= drop_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CORES; k++)
      if (hit[k] && (!hold_v[k] || gmask[k]))
        hold_n[k] <= nonce_i[k*NONCE_W +: NONCE_W];
  end

  nonce_fifo #(
    .T     (frame_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (grant),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (fill_level)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    bit_d   = nonce_o;
    vld_d   = 1'b0;
    last_d  = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        bit_d = 1'b0;
        if (!empty && readready) begin
          pop     = 1'b1;
          sh_d    = rdata;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (readready) begin
          bit_d = sh_q[0];
          vld_d = 1'b1;
          sh_d  = sh_q >> 1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(FRAME_W - 1)) begin
            last_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sh_q          <= '0;
      cnt_q         <= '0;
      nonce_o       <= 1'b0;
      nonce_valid_o <= 1'b0;
      frame_last_o  <= 1'b0;
    end else begin
      state_q       <= state_d;
      sh_q          <= sh_d;
      cnt_q         <= cnt_d;
      nonce_o       <= bit_d;
      nonce_valid_o <= vld_d;
      frame_last_o  <= last_d;
    end
  end

endmodule
